// File: rtl/snake_pkg.sv
// Grid geometry and placement-FSM types shared by the food spawner, renderer and body store.
package snake_pkg;

    localparam int GRID_W_BITS = 5;
    localparam int GRID_H_BITS = 4;
    localparam int IDX_BITS    = GRID_W_BITS + GRID_H_BITS;
    localparam int CELLS       = 1 << IDX_BITS;

    typedef logic [IDX_BITS-1:0]    cell_idx_t;
    typedef logic [GRID_W_BITS-1:0] cell_x_t;
    typedef logic [GRID_H_BITS-1:0] cell_y_t;

    typedef enum logic [1:0] {IDLE, QRY, CHK} state_e;
    typedef enum logic       {RAND, SCAN}     mode_e;

    // Cell index layout is {y, x}.
    function automatic cell_x_t idx_x(cell_idx_t idx);
        return idx[GRID_W_BITS-1:0];
    endfunction

    function automatic cell_y_t idx_y(cell_idx_t idx);
        return idx[IDX_BITS-1:GRID_W_BITS];
    endfunction

endpackage

// File: rtl/food_spawner_if.sv
// Spawner bundle: random source, spawn request, occupancy query/answer and placement results.
interface food_spawner_if;
    import snake_pkg::*;

    cell_idx_t rand_num;
    logic      spawn_req;
    logic      q_valid;
    cell_idx_t q_idx;
    logic      occupied;
    cell_x_t   food_x;
    cell_y_t   food_y;
    logic      food_valid;
    logic      done;
    logic      fail;
    logic      busy;

    modport master (
        output rand_num, spawn_req, occupied,
        input  q_valid, q_idx, food_x, food_y, food_valid, done, fail, busy
    );

    modport slave (
        input  rand_num, spawn_req, occupied,
        output q_valid, q_idx, food_x, food_y, food_valid, done, fail, busy
    );

endinterface

// File: rtl/food_spawner.sv
// Places food on a free grid cell: up to MAX_TRIES random candidates, then a wrap-around linear scan.
module food_spawner
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input logic           clk,
    input logic           rst,
    food_spawner_if.slave sp
);

    state_e    state;
    mode_e     mode;
    cell_idx_t cand;
    cell_idx_t cand_inc;
    logic [7:0]          try_cnt;
    logic [IDX_BITS-1:0] scan_cnt;

    assign cand_inc = cand + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode          <= RAND;
            cand          <= '0;
            try_cnt       <= '0;
            scan_cnt      <= '0;
            sp.q_valid    <= 1'b0;
            sp.q_idx      <= '0;
            sp.food_x     <= '0;
            sp.food_y     <= '0;
            sp.food_valid <= 1'b0;
            sp.done       <= 1'b0;
            sp.fail       <= 1'b0;
            sp.busy       <= 1'b0;
        end else begin
            sp.done    <= 1'b0;
            sp.fail    <= 1'b0;
            sp.q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A request coinciding with done/fail is still the tail of the previous placement.
                    if (sp.spawn_req && !sp.done && !sp.fail) begin
                        cand          <= sp.rand_num;
                        sp.q_idx      <= sp.rand_num;
                        sp.q_valid    <= 1'b1;
                        try_cnt       <= 8'd1;
                        scan_cnt      <= '0;
                        mode          <= RAND;
                        sp.food_valid <= 1'b0;
                        sp.busy       <= 1'b1;
                        state         <= QRY;
                    end
                end
                QRY: state <= CHK;
                CHK: begin
                    if (!sp.occupied) begin
                        sp.food_x     <= idx_x(cand);
                        sp.food_y     <= idx_y(cand);
                        sp.food_valid <= 1'b1;
                        sp.done       <= 1'b1;
                        sp.busy       <= 1'b0;
                        state         <= IDLE;
                    end else if (mode == RAND) begin
                        if (try_cnt < 8'(MAX_TRIES)) begin
                            cand     <= sp.rand_num;
                            sp.q_idx <= sp.rand_num;
                            try_cnt  <= try_cnt + 8'd1;
                        end else begin
                            // Scan starts past the last rejected random cell and wraps.
                            mode     <= SCAN;
                            cand     <= cand_inc;
                            sp.q_idx <= cand_inc;
                            scan_cnt <= 9'd1;
                        end
                        sp.q_valid <= 1'b1;
                        state      <= QRY;
                    end else if (scan_cnt < cell_idx_t'(CELLS - 1)) begin
                        cand       <= cand_inc;
                        sp.q_idx   <= cand_inc;
                        scan_cnt   <= scan_cnt + 1'b1;
                        sp.q_valid <= 1'b1;
                        state      <= QRY;
                    end else begin
                        sp.fail <= 1'b1;
                        sp.busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Directed and randomized placement scenarios checked against a list-walking reference model.
module tb_food_spawner;

    localparam int MAXT  = 8;
    localparam int NCELL = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    food_spawner_if sif();

    food_spawner #(.MAX_TRIES(MAXT)) dut (
        .clk (clk),
        .rst (rst),
        .sp  (sif)
    );

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit   occ [NCELL];
    int   rlist[$];
    int   qlog[$];
    int   exp_q[$];
    bit   exp_ok;
    int   exp_idx;
    int   done_cnt = 0;
    int   fail_cnt = 0;
    int   end_cyc = 0;
    logic end_busy = 1'b0;
    bit   pend_v = 1'b0;
    logic [8:0] pend_idx = '0;

    // Occupancy store with one-cycle answer latency plus a random source that
    // presents list entry k after k queries have been issued; also logs outcomes.
    always @(negedge clk) begin
        sif.occupied = pend_v ? logic'(occ[pend_idx]) : 1'b0;
        pend_v   = (sif.q_valid === 1'b1);
        pend_idx = sif.q_idx;
        if (sif.q_valid === 1'b1) qlog.push_back(int'(sif.q_idx));
        if (qlog.size() < rlist.size()) sif.rand_num = 9'(rlist[qlog.size()]);
        else                            sif.rand_num = 9'($urandom_range(0, NCELL - 1));
        if (sif.done === 1'b1) begin done_cnt++; end_cyc = cyc; end_busy = sif.busy; end
        if (sif.fail === 1'b1) begin fail_cnt++; end_cyc = cyc; end_busy = sif.busy; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_occ(input bit v);
        for (int i = 0; i < NCELL; i++) occ[i] = v;
    endtask

    task automatic pad_list();
        while (rlist.size() < 16) rlist.push_back($urandom_range(0, NCELL - 1));
    endtask

    // Reference: walk the random list, then scan forward from the last random cell.
    task automatic model();
        int c;
        exp_q.delete();
        exp_ok  = 1'b0;
        exp_idx = 0;
        c = 0;
        for (int t = 0; t < MAXT; t++) begin
            c = rlist[t];
            exp_q.push_back(c);
            if (!occ[c]) begin exp_ok = 1'b1; exp_idx = c; return; end
        end
        for (int s = 1; s < NCELL; s++) begin
            c = (c + 1) % NCELL;
            exp_q.push_back(c);
            if (!occ[c]) begin exp_ok = 1'b1; exp_idx = c; return; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_spawn(output int st);
        qlog.delete();
        done_cnt = 0;
        fail_cnt = 0;
        tick();
        sif.spawn_req = 1'b1;
        st = cyc;
        tick();
        sif.spawn_req = 1'b0;
    endtask

    task automatic run_case(input string tag);
        int  st;
        bit  seq_ok;
        model();
        start_spawn(st);
        chk({tag, "_busy_hi"}, sif.busy, 1);
        for (int i = 0; i < 1200 && (done_cnt + fail_cnt) == 0; i++) tick();
        chk({tag, "_finished"}, ((done_cnt + fail_cnt) != 0), 1);
        repeat (4) tick();
        chk({tag, "_qcount"}, qlog.size(), exp_q.size());
        seq_ok = (qlog.size() == exp_q.size());
        for (int i = 0; i < qlog.size() && i < exp_q.size(); i++)
            if (qlog[i] != exp_q[i]) seq_ok = 1'b0;
        chk({tag, "_qseq"}, seq_ok, 1);
        chk({tag, "_done_cnt"}, done_cnt, exp_ok ? 1 : 0);
        chk({tag, "_fail_cnt"}, fail_cnt, exp_ok ? 0 : 1);
        chk({tag, "_latency"}, end_cyc - st, 2 * exp_q.size() + 1);
        chk({tag, "_busy_end"}, end_busy, 0);
        chk({tag, "_food_valid"}, sif.food_valid, exp_ok);
        if (exp_ok) begin
            chk({tag, "_food_x"}, sif.food_x, exp_idx % 32);
            chk({tag, "_food_y"}, sif.food_y, exp_idx / 32);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        sif.spawn_req = 1'b0;
        fill_occ(1'b0);
        repeat (3) tick();
        chk("reset_outputs", {sif.q_valid, sif.q_idx, sif.food_x, sif.food_y,
                              sif.food_valid, sif.done, sif.fail, sif.busy}, 0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {sif.q_valid, sif.busy, sif.done, sif.fail}, 0);

        // Empty board, first candidate accepted
        rlist = '{37};
        pad_list();
        run_case("empty");
        chk("empty_x5", sif.food_x, 5);
        chk("empty_y1", sif.food_y, 1);

        // Three random rejections, fourth accepted
        fill_occ(1'b0);
        occ[10] = 1; occ[20] = 1; occ[30] = 1;
        rlist = '{10, 20, 30, 40};
        pad_list();
        run_case("retry");
        chk("retry_x8", sif.food_x, 8);

        // Random phase exhausted on 511, scan wraps to 0..3
        fill_occ(1'b1);
        occ[3] = 0;
        rlist.delete();
        for (int i = 0; i < 16; i++) rlist.push_back(511);
        run_case("scanwrap");
        chk("scanwrap_x3", sif.food_x, 3);
        chk("scanwrap_q12", qlog.size(), 12);

        // Full board
        fill_occ(1'b1);
        rlist.delete();
        pad_list();
        run_case("full");
        chk("full_q519", qlog.size(), 519);

        // Requests during the retry CHK and in the done cycle are dropped
        fill_occ(1'b0);
        occ[50] = 1;
        rlist = '{50, 60};
        pad_list();
        start_spawn(st);
        repeat (3) tick();
        sif.spawn_req = 1'b1;
        tick();
        chk("busyrej_done_now", sif.done, 1);
        tick();
        sif.spawn_req = 1'b0;
        repeat (6) tick();
        chk("busyrej_qcount", qlog.size(), 2);
        chk("busyrej_done_cnt", done_cnt, 1);
        chk("busyrej_x", sif.food_x, 28);
        chk("busyrej_y", sif.food_y, 1);

        // Asynchronous reset in the middle of a scan
        fill_occ(1'b1);
        rlist.delete();
        pad_list();
        start_spawn(st);
        repeat (40) tick();
        chk("rstmid_in_scan", (qlog.size() > MAXT), 1);
        chk("rstmid_busy", sif.busy, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {sif.q_valid, sif.q_idx, sif.food_x, sif.food_y,
                               sif.food_valid, sif.done, sif.fail, sif.busy}, 0);
        repeat (2) tick();
        rst = 1'b0;
        fill_occ(1'b0);
        rlist = '{100};
        pad_list();
        run_case("after_rst");
        chk("after_rst_x4", sif.food_x, 4);
        chk("after_rst_y3", sif.food_y, 3);

        // Randomized boards of varying density
        for (int n = 0; n < 9; n++) begin
            rlist.delete();
            pad_list();
            if (n % 3 == 2) begin
                fill_occ(1'b1);
                occ[$urandom_range(0, NCELL - 1)] = 0;
            end else begin
                for (int i = 0; i < NCELL; i++)
                    occ[i] = ($urandom_range(0, 99) < ((n % 3 == 0) ? 50 : 90));
            end
            run_case($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
